sgm_to_bcd_capture: RTL and testbench

SGM_TO_BCD_CAPTURE -- requirements
Module: sgm_to_bcd_capture

---
 rtl/sgm_to_bcd_capture_if.sv | 34 +++
 rtl/sgm_to_bcd_capture.sv | 186 ++++++++++++++++++
 tb/tb_sgm_to_bcd_capture.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sgm_to_bcd_capture_if.sv
// Scanned 7-segment input and frame valid/ready output bundle
// for sgm_to_bcd_capture.
interface sgm_to_bcd_capture_if;
  logic [3:0]  an_in;
  logic [7:0]  sgm_in;
  logic        frame_ready;
  logic [15:0] dig_out;
  logic [3:0]  dp_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        overrun;

  modport master (
    output an_in,
    output sgm_in,
    output frame_ready,
    input  dig_out,
    input  dp_out,
    input  err_out,
    input  frame_valid,
    input  overrun
  );

  modport slave (
    input  an_in,
    input  sgm_in,
    input  frame_ready,
    output dig_out,
    output dp_out,
    output err_out,
    output frame_valid,
    output overrun
  );
endinterface

// File: rtl/sgm_to_bcd_capture.sv
// Samples a multiplexed 4-digit 7-segment display, decodes each
// stable digit and publishes whole frames over valid/ready.
module sgm_to_bcd_capture #(
  parameter int unsigned STABLE_CYC = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  sgm_to_bcd_capture_if.slave bus
);

  typedef enum logic {
    SYNC,
    COLLECT
  } state_e;

  localparam logic [3:0] STB = 4'(STABLE_CYC);

  state_e      state_q;
  logic [3:0]  an_q;
  logic [7:0]  sgm_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [3:0]  seen_q;
  logic [15:0] slot_code_q;
  logic [3:0]  slot_dp_q;
  logic [3:0]  slot_err_q;
  logic [15:0] dig_q;
  logic [3:0]  dp_q;
  logic [3:0]  err_q;
  logic        fv_q;
  logic        ovr_q;

  logic        is_digit;
  logic        is_blank;
  logic        glitch;
  logic        changed;
  logic        capture;
  logic        complete;
  logic        publish;
  logic [1:0]  idx;
  logic [3:0]  cap_bit;
  logic [3:0]  code;
  logic        bad;
  logic [15:0] mrg_code;
  logic [3:0]  mrg_dp;
  logic [3:0]  mrg_err;

  always_comb begin
    is_digit = 1'b0;
    is_blank = 1'b0;
    idx      = 2'd0;
    unique case (bus.an_in)
      4'b1110: begin is_digit = 1'b1; idx = 2'd0; end
      4'b1101: begin is_digit = 1'b1; idx = 2'd1; end
      4'b1011: begin is_digit = 1'b1; idx = 2'd2; end
      4'b0111: begin is_digit = 1'b1; idx = 2'd3; end
      4'b1111: is_blank = 1'b1;
      default: ;
    endcase
  end

  assign glitch  = !is_digit && !is_blank;
  assign changed = (bus.an_in != an_q) || (bus.sgm_in != sgm_q);
  assign cap_bit = 4'b0001 << idx;

  always_comb begin
    cnt_d = cnt_q;
    if (!is_digit) begin
      cnt_d = 4'd0;
    end else if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q < STB) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Fires only on the edge into saturation: one capture per dwell.
  assign capture  = is_digit && (cnt_d == STB) && (cnt_q != STB);
  assign complete = capture && (state_q == COLLECT)
                 && ((seen_q | cap_bit) == 4'hF);
  assign publish  = !fv_q || bus.frame_ready;

  always_comb begin
    code = 4'd12;
    bad  = 1'b0;
    unique case (bus.sgm_in[6:0])
      7'h40: code = 4'd0;
      7'h79: code = 4'd1;
      7'h24: code = 4'd2;
      7'h30: code = 4'd3;
      7'h19: code = 4'd4;
      7'h12: code = 4'd5;
      7'h02: code = 4'd6;
      7'h78: code = 4'd7;
      7'h00: code = 4'd8;
      7'h10: code = 4'd9;
      7'h08: code = 4'd14;
      7'h0C: code = 4'd15;
      7'h7F: code = 4'd10;
      default: begin
        code = 4'd12;
        bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    mrg_code = slot_code_q;
    mrg_dp   = slot_dp_q;
    mrg_err  = slot_err_q;
    mrg_code[{idx, 2'b00} +: 4] = code;
    mrg_dp[idx]  = ~bus.sgm_in[7];
    mrg_err[idx] = bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      an_q        <= 4'hF;
      sgm_q       <= 8'hFF;
      cnt_q       <= 4'd0;
      seen_q      <= 4'd0;
      slot_code_q <= 16'h0000;
      slot_dp_q   <= 4'd0;
      slot_err_q  <= 4'd0;
      dig_q       <= 16'h0000;
      dp_q        <= 4'd0;
      err_q       <= 4'd0;
      fv_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      an_q  <= bus.an_in;
      sgm_q <= bus.sgm_in;
      cnt_q <= cnt_d;
      ovr_q <= 1'b0;
      if (fv_q && bus.frame_ready) begin
        fv_q <= 1'b0;
      end
      unique case (state_q)
        SYNC: begin
          if (capture && (idx == 2'd0)) begin
            slot_code_q <= mrg_code;
            slot_dp_q   <= mrg_dp;
            slot_err_q  <= mrg_err;
            seen_q      <= 4'b0001;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (glitch) begin
            state_q     <= SYNC;
            seen_q      <= 4'd0;
            slot_code_q <= 16'h0000;
            slot_dp_q   <= 4'd0;
            slot_err_q  <= 4'd0;
          end else if (capture) begin
            slot_code_q <= mrg_code;
            slot_dp_q   <= mrg_dp;
            slot_err_q  <= mrg_err;
            if (complete) begin
              seen_q <= 4'd0;
              if (publish) begin
                dig_q <= mrg_code;
                dp_q  <= mrg_dp;
                err_q <= mrg_err;
                fv_q  <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              seen_q <= seen_q | cap_bit;
            end
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign bus.dig_out     = dig_q;
  assign bus.dp_out      = dp_q;
  assign bus.err_out     = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_sgm_to_bcd_capture.sv
// Directed bench for sgm_to_bcd_capture: scans, stability edge,
// backpressure, bad patterns, glitches and mid-frame reset.
module tb_sgm_to_bcd_capture;

  logic clk;
  logic rst_n;

  sgm_to_bcd_capture_if bus ();

  sgm_to_bcd_capture #(
    .STABLE_CYC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          checks  = 0;
  int          errors  = 0;
  int          acc_cnt = 0;
  int          ovr_cnt = 0;
  logic [15:0] acc_dig = 16'h0000;
  logic [3:0]  acc_dp  = 4'h0;
  logic [3:0]  acc_err = 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every accepted frame and every overrun cycle.
  always @(negedge clk) begin
    if (bus.frame_valid && bus.frame_ready) begin
      acc_cnt++;
      acc_dig = bus.dig_out;
      acc_dp  = bus.dp_out;
      acc_err = bus.err_out;
    end
    if (bus.overrun) ovr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] an,
                       input logic [7:0] sg,
                       input int n);
    repeat (n) begin
      bus.an_in  = an;
      bus.sgm_in = sg;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    dwell(4'b1110, s0, 6);
    dwell(4'b1101, s1, 6);
    dwell(4'b1011, s2, 6);
    dwell(4'b0111, s3, 6);
    dwell(4'b1111, 8'hFF, 2);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.an_in       = 4'hF;
    bus.sgm_in      = 8'hFF;
    bus.frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dig", bus.dig_out, 16'h0000);
    check("rst_dp", {12'h0, bus.dp_out}, 16'h0);
    check("rst_err", {12'h0, bus.err_out}, 16'h0);
    check("rst_fv", {15'h0, bus.frame_valid}, 16'h0);
    check("rst_ovr", {15'h0, bus.overrun}, 16'h0);
    rst_n = 1'b1;
    dwell(4'hF, 8'hFF, 2);

    // Normal scan with exact publish latency
    bus.frame_ready = 1'b1;
    dwell(4'b1110, 8'hC0, 6);
    dwell(4'b1101, 8'hF9, 6);
    dwell(4'b1011, 8'hA4, 6);
    dwell(4'b0111, 8'hB0, 3);
    check("norm_fv_early", {15'h0, bus.frame_valid}, 16'h0);
    dwell(4'b0111, 8'hB0, 1);
    check("norm_fv", {15'h0, bus.frame_valid}, 16'h1);
    check("norm_dig", bus.dig_out, 16'h3210);
    check("norm_dp", {12'h0, bus.dp_out}, 16'h0);
    check("norm_err", {12'h0, bus.err_out}, 16'h0);
    dwell(4'b0111, 8'hB0, 2);
    dwell(4'hF, 8'hFF, 2);
    check("norm_fv_clr", {15'h0, bus.frame_valid}, 16'h0);
    check("norm_hold", bus.dig_out, 16'h3210);
    check("norm_acc", 16'(acc_cnt), 16'd1);

    // A/P codes and decimal points
    scan(8'hFF, 8'h40, 8'h0C, 8'h08);
    check("ap_acc", 16'(acc_cnt), 16'd2);
    check("ap_dig", acc_dig, 16'hEF0A);
    check("ap_dp", {12'h0, acc_dp}, 16'h000E);
    check("ap_err", {12'h0, acc_err}, 16'h0);

    // Stability boundary: 3-cycle dwell is ignored, 4 captures
    dwell(4'b1110, 8'hC0, 6);
    dwell(4'b1101, 8'hF9, 3);
    dwell(4'b1011, 8'hA4, 6);
    dwell(4'b0111, 8'hB0, 6);
    check("stb3_acc", 16'(acc_cnt), 16'd2);
    check("stb3_fv", {15'h0, bus.frame_valid}, 16'h0);
    dwell(4'b1101, 8'hF9, 3);
    check("stb4_early", {15'h0, bus.frame_valid}, 16'h0);
    dwell(4'b1101, 8'hF9, 1);
    check("stb4_fv", {15'h0, bus.frame_valid}, 16'h1);
    check("stb4_dig", bus.dig_out, 16'h3210);
    dwell(4'hF, 8'hFF, 2);
    check("stb4_acc", 16'(acc_cnt), 16'd3);

    // Backpressure across two scans
    bus.frame_ready = 1'b0;
    scan(8'h92, 8'h82, 8'hF8, 8'h80);
    check("bp_fv1", {15'h0, bus.frame_valid}, 16'h1);
    check("bp_dig1", bus.dig_out, 16'h8765);
    scan(8'h90, 8'hC0, 8'hC0, 8'hC0);
    check("bp_fv2", {15'h0, bus.frame_valid}, 16'h1);
    check("bp_dig2", bus.dig_out, 16'h8765);
    check("bp_ovr", 16'(ovr_cnt), 16'd1);
    bus.frame_ready = 1'b1;
    dwell(4'hF, 8'hFF, 1);
    check("bp_fv_drop", {15'h0, bus.frame_valid}, 16'h0);
    check("bp_hold", bus.dig_out, 16'h8765);
    check("bp_acc", 16'(acc_cnt), 16'd4);

    // Unrecognised pattern on digit 2
    scan(8'hC0, 8'hF9, 8'hFE, 8'hB0);
    check("bad_acc", 16'(acc_cnt), 16'd5);
    check("bad_dig", acc_dig, 16'h3C10);
    check("bad_err", {12'h0, acc_err}, 16'h0004);
    check("bad_dp", {12'h0, acc_dp}, 16'h0);

    // Glitch mid-frame forces resync on digit 0
    dwell(4'b1110, 8'hC0, 6);
    dwell(4'b1101, 8'hF9, 6);
    dwell(4'b1100, 8'hC0, 2);
    dwell(4'b1011, 8'hA4, 6);
    dwell(4'b0111, 8'hB0, 6);
    dwell(4'hF, 8'hFF, 2);
    check("gl_nofr", 16'(acc_cnt), 16'd5);
    scan(8'h92, 8'h92, 8'hA4, 8'hB0);
    check("gl_acc", 16'(acc_cnt), 16'd6);
    check("gl_dig", acc_dig, 16'h3255);

    // Reset mid-frame
    dwell(4'b1110, 8'hC0, 6);
    dwell(4'b1101, 8'hF9, 6);
    dwell(4'b1011, 8'hA4, 2);
    check("mr_pre", bus.dig_out, 16'h3255);
    rst_n = 1'b0;
    #1;
    check("mr_dig", bus.dig_out, 16'h0000);
    check("mr_fv", {15'h0, bus.frame_valid}, 16'h0);
    bus.an_in  = 4'hF;
    bus.sgm_in = 8'hFF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dwell(4'b1101, 8'hA4, 6);
    dwell(4'b1011, 8'hB0, 6);
    dwell(4'b0111, 8'h99, 6);
    dwell(4'hF, 8'hFF, 2);
    check("mr_nofr", 16'(acc_cnt), 16'd6);
    check("mr_fv2", {15'h0, bus.frame_valid}, 16'h0);
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check("mr_acc", 16'(acc_cnt), 16'd7);
    check("mr_dig2", acc_dig, 16'h4321);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
